serial_mag_comparator: RTL and testbench

//  Word-level magnitude comparator. Resolves A>B, A==B or A<B on WIDTH-bit unsigned operands
//  by walking 2-bit digit pairs MSB-first, one pair per clock, through a 2-bit compare slice.

---
 rtl/serial_mag_comparator_pkg.sv | 17 +
 rtl/serial_mag_comparator_if.sv | 27 ++
 rtl/serial_mag_comparator_cmp2_slice.sv | 15 +
 rtl/serial_mag_comparator.sv | 120 ++++++++++++
 tb/tb_serial_mag_comparator.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/serial_mag_comparator_pkg.sv
// Shared definitions for the serial magnitude comparator: FSM encoding and
// one-hot result codes ordered {gt, eq, lt}.
`timescale 1ns/1ps
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

endpackage

// File: rtl/serial_mag_comparator_if.sv
// Request/result bundle between the comparator and the control logic that
// launches comparisons and consumes the one-hot result.
`timescale 1ns/1ps
interface serial_mag_comparator_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             gt;
  logic             eq;
  logic             lt;

  modport master (
    output start, a, b,
    input  busy, done, gt, eq, lt
  );

  modport slave (
    input  start, a, b,
    output busy, done, gt, eq, lt
  );

endinterface

// File: rtl/serial_mag_comparator_cmp2_slice.sv
// Combinational 2-bit unsigned compare producing a one-hot gt/eq/lt result.
`timescale 1ns/1ps
module cmp2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       gt,
  output logic       eq,
  output logic       lt
);

  assign gt = (x > y);
  assign eq = (x == y);
  assign lt = (x < y);

endmodule

// File: rtl/serial_mag_comparator.sv
// Walks operand digit pairs MSB-first, one per clock, and stops at the first
// differing digit; result flags stay held until the next accepted start.
`timescale 1ns/1ps
module serial_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  serial_mag_comparator_if.slave        bus
);

  localparam int ND = WIDTH / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [CW-1:0]    cnt;
  logic [2:0]       result;
  logic [2:0]       result_next;
  logic             busy_q;
  logic             done_q;
  logic             load;
  logic             shift;
  logic             slice_gt;
  logic             slice_eq;
  logic             slice_lt;

  cmp2_slice u_slice (
    .x  (sa[WIDTH-1:WIDTH-2]),
    .y  (sb[WIDTH-1:WIDTH-2]),
    .gt (slice_gt),
    .eq (slice_eq),
    .lt (slice_lt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    result_next = result;
    load        = 1'b0;
    shift       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_next  = COMPARE;
          result_next = CMP_NONE;
          load        = 1'b1;
        end
      end
      COMPARE: begin
        if (slice_gt) begin
          state_next  = DONE;
          result_next = CMP_GT;
        end else if (slice_lt) begin
          state_next  = DONE;
          result_next = CMP_LT;
        end else if (slice_eq && (cnt == '0)) begin
          state_next  = DONE;
          result_next = CMP_EQ;
        end else begin
          shift = 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are captured once so the requester may change a/b right after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa  <= '0;
      sb  <= '0;
      cnt <= '0;
    end else if (load) begin
      sa  <= bus.a;
      sb  <= bus.b;
      cnt <= CW'(ND - 1);
    end else if (shift) begin
      sa  <= sa << 2;
      sb  <= sb << 2;
      cnt <= cnt - CW'(1);
    end
  end

  // Status outputs come from flops loaded with the next-state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= CMP_NONE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      result <= result_next;
      busy_q <= (state_next == COMPARE);
      done_q <= (state_next == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.gt   = result[2];
  assign bus.eq   = result[1];
  assign bus.lt   = result[0];

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed and randomised checks of the serial magnitude comparator at WIDTH=8.
`timescale 1ns/1ps
module tb_serial_mag_comparator;

  localparam int WIDTH = 8;
  localparam int ND    = WIDTH / 2;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  serial_mag_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_mag_comparator #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] status();
    return {bus.done, bus.gt, bus.eq, bus.lt};
  endfunction

  // Independent reference: first differing digit MSB-first decides the result.
  task automatic ref_compare(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             output logic [2:0] flags, output int k);
    logic [1:0] da;
    logic [1:0] db;
    flags = 3'b010;
    k     = ND;
    for (int i = ND - 1; i >= 0; i--) begin
      da = a[2*i +: 2];
      db = b[2*i +: 2];
      if (da != db) begin
        flags = (da > db) ? 3'b100 : 3'b001;
        k     = ND - i;
        break;
      end
    end
  endtask

  // Presents a request for one cycle, then scrambles the operands after accept.
  task automatic apply_stimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = WIDTH'($urandom);
    bus.b     = WIDTH'($urandom);
  endtask

  // Starts at the negedge after the accepting edge; measures k and checks flags.
  task automatic wait_and_check(input string tag, input logic [2:0] exp_flags,
                                input int exp_k);
    int   k;
    logic inflight_ok;
    k = -1;
    inflight_ok = (bus.busy === 1'b1) && (status() === 4'b0000);
    for (int j = 1; j <= ND + 2; j++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        k = j;
        break;
      end
      if (!((bus.busy === 1'b1) && (status() === 4'b0000))) inflight_ok = 1'b0;
    end
    check_output({tag, "_inflight"}, 32'(inflight_ok), 32'd1);
    check_output({tag, "_k"}, 32'(k), 32'(exp_k));
    check_output({tag, "_flags"}, 32'({bus.busy, bus.gt, bus.eq, bus.lt}), 32'({1'b0, exp_flags}));
    @(negedge clk);
    check_output({tag, "_held"}, 32'(status()), 32'({1'b0, exp_flags}));
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [2:0] exp_flags,
                        input int exp_k);
    apply_stimulus(a, b);
    wait_and_check(tag, exp_flags, exp_k);
  endtask

  initial begin
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [2:0]       rflags;
    int               rk;
    logic             saw_done;

    errors    = 0;
    checks    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;

    #1;
    check_output("reset_outputs", 32'({bus.busy, status()}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("idle_outputs", 32'({bus.busy, status()}), 32'd0);

    $display("[TB] directed vectors");
    run_op("t1_gt",    8'hA5, 8'h25, 3'b100, 1);
    run_op("t2_eq",    8'h3C, 8'h3C, 3'b010, 4);
    run_op("t3_lt",    8'h12, 8'h13, 3'b001, 4);
    run_op("t3_gt",    8'hFF, 8'h00, 3'b100, 1);
    run_op("zero_eq",  8'h00, 8'h00, 3'b010, 4);
    run_op("ones_eq",  8'hFF, 8'hFF, 3'b010, 4);
    run_op("k2_lt",    8'h4C, 8'h5C, 3'b001, 2);
    run_op("k3_gt",    8'h2B, 8'h27, 3'b100, 3);

    $display("[TB] ignored starts");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h40;
    bus.b     = 8'h80;
    @(negedge clk);
    check_output("t4_busy", 32'({bus.busy, status()}), 32'b10000);
    bus.a = 8'hFF;
    bus.b = 8'h00;
    @(negedge clk);
    check_output("t4_done", 32'({bus.busy, status()}), 32'b01001);
    @(negedge clk);
    check_output("t4_idle", 32'({bus.busy, status()}), 32'b00001);
    @(negedge clk);
    check_output("t4_reaccept", 32'({bus.busy, status()}), 32'b10000);
    bus.start = 1'b0;
    wait_and_check("t4_second", 3'b100, 1);

    $display("[TB] reset mid-compare");
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h56;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("t5_before_reset", 32'({bus.busy, status()}), 32'b10000);
    rst_n = 1'b0;
    #1;
    check_output("t5_async_clear", 32'({bus.busy, status()}), 32'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (bus.done !== 1'b0) saw_done = 1'b1;
    end
    check_output("t5_no_done", 32'(saw_done), 32'd0);
    run_op("t5_gt", 8'h56, 8'h55, 3'b100, 4);

    $display("[TB] random sweep");
    for (int n = 0; n < 1000; n++) begin
      ra = WIDTH'($urandom);
      case ($urandom_range(3))
        0:       rb = ra;
        1:       rb = ra ^ WIDTH'(1 << $urandom_range(WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      ref_compare(ra, rb, rflags, rk);
      run_op("rand", ra, rb, rflags, rk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
